// File: rtl/uart_link_pkg.sv
// Shared types and constants for the UART link blocks.
// Arbiter state enum, ASCII CR/LF bytes, default byte width, index-width helper.
package uart_link_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    CR,
    LF,
    DONE
  } state_e;

  // Width of an index into n things, never below 1.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr, with wrap.
// Ports: req, rr_ptr in; one-hot grant and valid out.
module rr_pick
  import uart_link_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  // Each requester's distance from rr_ptr (mod NUM_REQ); the nearest wins.
  always_comb begin
    int best;
    int sel;
    int d;
    grant = '0;
    best  = NUM_REQ;
    sel   = 0;
    d     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(rr_ptr);
      if (d < 0) d = d + NUM_REQ;
      if (req[i] && d < best) begin
        best = d;
        sel  = i;
      end
    end
    valid = (best < NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = valid && (sel == i);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Whole-message round-robin arbiter in front of one UART TX byte port, optional CR/LF, stall watchdog.
// Ports: clk, reset_n, ena; req/req_data/req_last/req_ack per source; tx_*; grant, busy, status counters.
module uart_tx_arbiter
  import uart_link_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter bit APPEND_CRLF   = 1'b1,
  parameter int STALL_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ena,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic                          tx_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          msg_count,
  output logic [CNT_WIDTH-1:0]          abort_count
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int SW = idx_w(STALL_TIMEOUT + 1);

  localparam logic [SW-1:0]         STALL_LAST = SW'(STALL_TIMEOUT - 1);
  localparam logic [IW-1:0]         LAST_IDX   = IW'(NUM_REQ - 1);
  localparam logic [DATA_WIDTH-1:0] CR_BYTE    = DATA_WIDTH'(ASCII_CR);
  localparam logic [DATA_WIDTH-1:0] LF_BYTE    = DATA_WIDTH'(ASCII_LF);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]        stall_q, stall_d;
  logic                 aborted_q, aborted_d;
  logic [CNT_WIDTH-1:0] msg_q, msg_d;
  logic [CNT_WIDTH-1:0] abort_q, abort_d;

  logic [NUM_REQ-1:0]    pick_oh;
  logic                  pick_valid;
  logic                  own_req;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic [IW-1:0]         own_idx;
  logic                  xfer;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_pick (
    .req   (req),
    .rr_ptr(rr_ptr_q),
    .grant (pick_oh),
    .valid (pick_valid)
  );

  // Select the current owner's request lines.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    own_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        own_req  = req[i];
        own_last = req_last[i];
        own_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        own_idx  = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      stall_q   <= '0;
      aborted_q <= 1'b0;
      msg_q     <= '0;
      abort_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      stall_q   <= stall_d;
      aborted_q <= aborted_d;
      msg_q     <= msg_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    stall_d   = stall_q;
    aborted_d = aborted_q;
    msg_d     = msg_q;
    abort_d   = abort_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_d   = pick_oh;
            stall_d   = '0;
            aborted_d = 1'b0;
            state_d   = SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            stall_d = '0;
            if (own_last) state_d = APPEND_CRLF ? CR : DONE;
          end else if (!own_req) begin
            // This low cycle is the STALL_TIMEOUT-th in a row: abort.
            if (stall_q == STALL_LAST) begin
              stall_d   = '0;
              aborted_d = 1'b1;
              if (abort_q != '1) abort_d = abort_q + 1'b1;
              state_d   = APPEND_CRLF ? CR : DONE;
            end else begin
              stall_d = stall_q + 1'b1;
            end
          end
        end
        CR: if (xfer) state_d = LF;
        LF: if (xfer) state_d = DONE;
        DONE: begin
          if (!aborted_q && msg_q != '1) msg_d = msg_q + 1'b1;
          rr_ptr_d = (own_idx == LAST_IDX) ? '0 : own_idx + 1'b1;
          grant_d  = '0;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    req_ack  = '0;
    if (reset_n && ena) begin
      unique case (state_q)
        SEND:    tx_valid = own_req;
        CR, LF:  tx_valid = 1'b1;
        default: tx_valid = 1'b0;
      endcase
    end
    if (tx_valid) begin
      unique case (state_q)
        CR:      tx_data = CR_BYTE;
        LF:      tx_data = LF_BYTE;
        default: tx_data = own_data;
      endcase
    end
    if (xfer && state_q == SEND) req_ack = grant_q;
  end

  assign xfer        = tx_valid && tx_ready;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign msg_count   = msg_q;
  assign abort_count = abort_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ message sources, e.g. LED-change ("LD: 0x....") and 7-segment-change ("7S: 0x....") generators.
- Grants whole messages, not single bytes, using round-robin priority.
- Streams the granted source's bytes to the TX byte interface and optionally appends a CR/LF terminator.
- A stall watchdog aborts a message whose source stops presenting data mid-message.

Parameters:
- NUM_REQ, 2: number of requesting message sources.
- DATA_WIDTH, 8: byte width.
- APPEND_CRLF, 1: 1 = send 0x0D then 0x0A after each message; 0 = no terminator.
- STALL_TIMEOUT, 64: cycles in SEND with the granted req low before abort. Must be ≥ 1.
- CNT_WIDTH, 8: width of the status counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- ena  in  1  global enable; when low, all state is frozen
- req  in  NUM_REQ  per-source "byte available"; held high while a message is pending
- req_data  in  NUM_REQ*DATA_WIDTH  per-source current byte; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  marks the current byte as the final byte of the message
- req_ack  out  NUM_REQ  one-hot pulse: the granted source's byte was consumed
- tx_ready  in  1  transmitter can accept a byte
- tx_valid  out  1  tx_data is valid
- tx_data  out  DATA_WIDTH  byte to transmit
- grant  out  NUM_REQ  registered one-hot current owner; 0 when idle
- busy  out  1  state != IDLE
- msg_count  out  CNT_WIDTH  completed messages; saturating
- abort_count  out  CNT_WIDTH  watchdog aborts; saturating

Behaviour:
- Reset: sync, active-low; clock clk. All of the following hold in the same cycle reset_n is sampled low:
  - state = IDLE, grant = 0, rr_ptr = 0, stall counter = 0, both status counters = 0.
  - tx_valid = 0, tx_data = 0, req_ack = 0.
  - A reset mid-message drops that message; no terminator is emitted.
- Transfer rule:
  - A byte moves when tx_valid && tx_ready && ena are all high.
  - Sources must hold req_data/req_last stable while req is high until req_ack is seen.
  - tx_valid is never dropped after assertion until accepted, except by reset or watchdog abort.
- States:
  - IDLE:
    - If any req bit is high, pick the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
    - Register grant and go to SEND. One cycle of arbitration latency; no byte moves in IDLE.
  - SEND (owner g):
    - tx_valid = req[g], tx_data = req_data[g] (combinational mux), req_ack[g] = transfer.
    - Transfer with req_last[g] high: go to CR if APPEND_CRLF, else DONE.
    - While req[g] is low, the stall counter increments; any transfer clears it.
    - When the stall counter reaches STALL_TIMEOUT: increment abort_count, go to CR (or DONE if APPEND_CRLF = 0).
  - CR: tx_valid = 1, tx_data = 0x0D; on transfer go to LF.
  - LF: tx_valid = 1, tx_data = 0x0A; on transfer go to DONE.
  - DONE (one cycle):
    - If the message was not aborted, increment msg_count.
    - rr_ptr = (g+1) mod NUM_REQ; grant = 0; go to IDLE.
- Timing and fairness:
  - Minimum gap between messages is 2 idle cycles (DONE + IDLE).
  - Requests from other sources during SEND/CR/LF are ignored; no preemption.
  - Simultaneous requests are resolved purely by rr_ptr.
  - A source whose req drops while in IDLE before the grant registers loses nothing; it is re-evaluated next cycle.
- ena low: no state or counter changes; tx_valid and req_ack forced to 0; the stall counter does not advance.
- tx_data is 0 whenever tx_valid is 0.
- Counters saturate at all-ones and never wrap.

Decomposition:
- Shared package uart_link_pkg:
  - state enum (IDLE, SEND, CR, LF, DONE)
  - ASCII_CR = 8'h0D, ASCII_LF = 8'h0A
  - DATA_WIDTH default
- One sub-module: rr_pick (combinational round-robin priority picker). Inputs req vector and rr_ptr; outputs one-hot grant and valid. Reusable by other arbiters in the link.

Test Plan:
- Single source: source 0 presents "LD: 0x1234" (10 bytes, last on byte 10), tx_ready always 1 -> tx_data stream equals those 10 bytes then 0x0D, 0x0A; msg_count = 1; grant = 01 throughout.
- Contention: both req high from the same cycle after reset -> source 0 message fully sent, then source 1's "7S: 0xABC0" + CRLF; no interleaving; rr_ptr then favours source 0 again.
- Backpressure: tx_ready toggles 1,0,0,1,... -> each byte is held stable while tx_valid is high and tx_ready low; req_ack pulses only on transfer cycles; output bytes are unchanged from the single-source case.
- Stall abort: STALL_TIMEOUT = 4; source 0 sends 3 bytes then drops req -> after 4 cycles, CR/LF is emitted, abort_count = 1, msg_count = 0, and the arbiter returns to IDLE.
- Reset mid-message: assert reset_n low after byte 5 -> next cycle tx_valid = 0, grant = 0, counters = 0; after release, a new request is granted starting from source 0.
- ena low during SEND for 10 cycles with req held -> no req_ack, tx_valid = 0, stall counter frozen; the stream resumes at the same byte once ena returns high.
